// File: rtl/toggle_seq_pkg.sv
// Shared types and helpers for the toggle sequencer.
// Optional abort support in the top is gated by TOGGLE_SEQ_ABORT_EN.
package toggle_seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        LOW  = 2'd2,
        DONE = 2'd3
    } toggle_seq_state_t;

    // A zero-length phase still lasts one cycle.
    function automatic int unsigned phase_load(input int unsigned len);
        return (len == 0) ? 0 : len - 1;
    endfunction

endpackage

// File: rtl/toggle_seq_ctrl_phase_counter.sv
// Down-counter timing a single HIGH or LOW phase.
// Optional abort support in the top is gated by TOGGLE_SEQ_ABORT_EN.
module phase_counter #(
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val_i,
    output logic             zero_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/toggle_seq_ctrl.sv
// Burst sequencer: N periods of LEVEL/0 phases, then a done pulse.
// Define TOGGLE_SEQ_ABORT_EN to add the abort input.
module toggle_seq_ctrl
    import toggle_seq_pkg::*;
#(
    parameter  int unsigned LEVEL = 1,
    parameter  int unsigned CNT_W = 8,
    localparam int unsigned OUT_W = $clog2(LEVEL) + 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [CNT_W-1:0] high_len,
    input  logic [CNT_W-1:0] low_len,
    input  logic [CNT_W-1:0] n_periods,
`ifdef TOGGLE_SEQ_ABORT_EN
    input  logic             abort,
`endif
    output logic             busy,
    output logic             done,
    output logic [OUT_W-1:0] level_out
);

    toggle_seq_state_t state_q, state_d;

    logic [CNT_W-1:0] hload_q, hload_d;
    logic [CNT_W-1:0] lload_q, lload_d;
    logic [CNT_W-1:0] per_q, per_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [OUT_W-1:0] level_q, level_d;

    logic             ph_load;
    logic [CNT_W-1:0] ph_load_val;
    logic             ph_zero;
    logic             abort_w;

`ifdef TOGGLE_SEQ_ABORT_EN
    assign abort_w = abort;
`else
    assign abort_w = 1'b0;
`endif

    phase_counter #(
        .CNT_W(CNT_W)
    ) u_phase (
        .clk       (clk),
        .rst_n     (reset_n),
        .load_i    (ph_load),
        .load_val_i(ph_load_val),
        .zero_o    (ph_zero)
    );

    always_comb begin
        state_d     = state_q;
        hload_d     = hload_q;
        lload_d     = lload_q;
        per_d       = per_q;
        ph_load     = 1'b0;
        ph_load_val = hload_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    hload_d = CNT_W'(phase_load(32'(high_len)));
                    lload_d = CNT_W'(phase_load(32'(low_len)));
                    per_d   = n_periods;
                    if (n_periods == '0) begin
                        state_d = DONE;
                    end else begin
                        state_d     = HIGH;
                        ph_load     = 1'b1;
                        ph_load_val = hload_d;
                    end
                end
            end
            HIGH: begin
                if (abort_w) begin
                    state_d = DONE;
                end else if (ph_zero) begin
                    state_d     = LOW;
                    ph_load     = 1'b1;
                    ph_load_val = lload_q;
                end
            end
            LOW: begin
                if (abort_w) begin
                    state_d = DONE;
                end else if (ph_zero) begin
                    per_d = per_q - CNT_W'(1);
                    if (per_q == CNT_W'(1)) begin
                        state_d = DONE;
                    end else begin
                        state_d     = HIGH;
                        ph_load     = 1'b1;
                        ph_load_val = hload_q;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
                per_d   = '0;
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs are decoded from the next state so they leave a flop.
    always_comb begin
        busy_d  = (state_d == HIGH) || (state_d == LOW);
        done_d  = (state_d == DONE);
        level_d = (state_d == HIGH) ? OUT_W'(LEVEL) : '0;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            hload_q <= '0;
            lload_q <= '0;
            per_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            level_q <= '0;
        end else begin
            state_q <= state_d;
            hload_q <= hload_d;
            lload_q <= lload_d;
            per_q   <= per_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            level_q <= level_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign level_out = level_q;

endmodule

// File: tb/tb_toggle_seq_ctrl.sv
// Randomized bench for toggle_seq_ctrl against a waveform-list model.
// Abort scenarios are exercised when TOGGLE_SEQ_ABORT_EN is defined.
module tb_toggle_seq_ctrl;

    localparam int unsigned LEVEL = 5;
    localparam int unsigned CNT_W = 8;
    localparam int unsigned OUT_W = $clog2(LEVEL) + 1;

    logic             clk = 1'b0;
    logic             reset_n;
    logic             start;
    logic [CNT_W-1:0] high_len;
    logic [CNT_W-1:0] low_len;
    logic [CNT_W-1:0] n_periods;
`ifdef TOGGLE_SEQ_ABORT_EN
    logic             abort;
`endif
    logic             busy;
    logic             done;
    logic [OUT_W-1:0] level_out;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    int unsigned exp_lvl[$];
    int unsigned exp_busy[$];
    int unsigned exp_done[$];

    toggle_seq_ctrl #(
        .LEVEL(LEVEL),
        .CNT_W(CNT_W)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .start    (start),
        .high_len (high_len),
        .low_len  (low_len),
        .n_periods(n_periods),
`ifdef TOGGLE_SEQ_ABORT_EN
        .abort    (abort),
`endif
        .busy     (busy),
        .done     (done),
        .level_out(level_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int unsigned obs,
                         input int unsigned exp);
        n_checks++;
        if (obs == exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // Expected output list, one entry per cycle after the start edge.
    task automatic build_exp(input int unsigned h, input int unsigned l,
                             input int unsigned n, input int abort_k);
        int unsigned he;
        int unsigned le;
        he = (h == 0) ? 1 : h;
        le = (l == 0) ? 1 : l;
        exp_lvl.delete();
        exp_busy.delete();
        exp_done.delete();
        for (int p = 0; p < int'(n); p++) begin
            for (int c = 0; c < int'(he); c++) begin
                exp_lvl.push_back(LEVEL);
                exp_busy.push_back(1);
                exp_done.push_back(0);
            end
            for (int c = 0; c < int'(le); c++) begin
                exp_lvl.push_back(0);
                exp_busy.push_back(1);
                exp_done.push_back(0);
            end
        end
        if (abort_k >= 0 && abort_k < exp_lvl.size()) begin
            while (exp_lvl.size() > abort_k + 1) begin
                void'(exp_lvl.pop_back());
                void'(exp_busy.pop_back());
                void'(exp_done.pop_back());
            end
        end
        exp_lvl.push_back(0);
        exp_busy.push_back(0);
        exp_done.push_back(1);
        exp_lvl.push_back(0);
        exp_busy.push_back(0);
        exp_done.push_back(0);
    endtask

    task automatic run(input int unsigned h, input int unsigned l,
                       input int unsigned n, input int abort_k,
                       input bit noise);
        build_exp(h, l, n, abort_k);
        @(negedge clk);
        start     = 1'b1;
        high_len  = CNT_W'(h);
        low_len   = CNT_W'(l);
        n_periods = CNT_W'(n);
        for (int i = 0; i < exp_lvl.size(); i++) begin
            @(negedge clk);
            check($sformatf("lvl[%0d]", i), level_out, exp_lvl[i]);
            check($sformatf("busy[%0d]", i), busy, exp_busy[i]);
            check($sformatf("done[%0d]", i), done, exp_done[i]);
            start = 1'b0;
            if (noise && exp_busy[i] == 1) begin
                start     = 1'($urandom_range(0, 1));
                high_len  = CNT_W'($urandom_range(0, 7));
                low_len   = CNT_W'($urandom_range(0, 7));
                n_periods = CNT_W'($urandom_range(0, 5));
            end
`ifdef TOGGLE_SEQ_ABORT_EN
            abort = (i == abort_k);
`endif
        end
        start = 1'b0;
`ifdef TOGGLE_SEQ_ABORT_EN
        abort = 1'b0;
`endif
    endtask

    initial begin
        reset_n   = 1'b0;
        start     = 1'b0;
        high_len  = '0;
        low_len   = '0;
        n_periods = '0;
`ifdef TOGGLE_SEQ_ABORT_EN
        abort     = 1'b0;
`endif
        repeat (2) @(negedge clk);
        check("rst_lvl", level_out, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        reset_n = 1'b1;
        @(negedge clk);
        check("idle_busy", busy, 0);

        run(3, 2, 2, -1, 1'b0);
        run(0, 0, 3, -1, 1'b0);
        run(4, 1, 0, -1, 1'b0);
        run(3, 2, 2, -1, 1'b1);

        // Asynchronous reset in the middle of the second HIGH phase.
        @(negedge clk);
        start     = 1'b1;
        high_len  = 3;
        low_len   = 2;
        n_periods = 4;
        @(negedge clk);
        start = 1'b0;
        repeat (6) @(negedge clk);
        check("pre_rst_lvl", level_out, LEVEL);
        #2 reset_n = 1'b0;
        #1;
        check("arst_lvl", level_out, 0);
        check("arst_busy", busy, 0);
        check("arst_done", done, 0);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);
        check("post_rst_busy", busy, 0);
        check("post_rst_lvl", level_out, 0);
        run(3, 2, 2, -1, 1'b0);

`ifdef TOGGLE_SEQ_ABORT_EN
        run(4, 4, 10, 18, 1'b0);
`endif

        for (int t = 0; t < 25; t++) begin
            int k;
            k = -1;
`ifdef TOGGLE_SEQ_ABORT_EN
            if ($urandom_range(0, 2) == 0) k = int'($urandom_range(0, 30));
`endif
            run($urandom_range(0, 5), $urandom_range(0, 5),
                $urandom_range(0, 4), k, 1'($urandom_range(0, 1)));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/toggle_seq_ctrl.md
# toggle_seq_ctrl

Programmable sequencer that drives a two-level output (0 / `LEVEL`) with configurable high and low phase durations for a configurable number of periods. Accepts a start request, captures the configuration, runs the burst autonomously, then signals completion. It replaces free-running alternation with a controlled, countable waveform source for downstream datapath stimulus.

## Interface
- `LEVEL`, default 1: value driven on `level_out` during the high phase.
- `CNT_W`, default 8: width of the phase-length and period-count fields.
- `OUT_W` (derived, not overridable) = `$clog2(LEVEL)+1`.

- `clk` in 1: single clock, all logic on the rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `start` in 1: burst request; sampled only in IDLE.
- `high_len` in CNT_W: high-phase length in cycles.
- `low_len` in CNT_W: low-phase length in cycles.
- `n_periods` in CNT_W: number of high+low periods.
- `busy` out 1: high while in HIGH or LOW.
- `done` out 1: one-cycle completion pulse.
- `level_out` out OUT_W: waveform output, registered.
- `abort` in 1: present only with `TOGGLE_SEQ_ABORT_EN`.

## Operation
- States: IDLE, HIGH, LOW, DONE.
- IDLE, `start`=1: capture `high_len`, `low_len`, `n_periods`.
  - If `n_periods`=0, go to DONE.
  - Otherwise go to HIGH.
- Zero phase length behaves as 1. Effective length is `max(len,1)`.
- HIGH: `level_out`=LEVEL for the effective `high_len` cycles, then go to LOW.
- LOW: `level_out`=0 for the effective `low_len` cycles.
  - At the end of the phase, decrement the remaining-period count.
  - If the remaining count is nonzero, go to HIGH. Otherwise go to DONE.
- DONE: `done`=1, `busy`=0, `level_out`=0 for one cycle, then go to IDLE.
- `start` outside IDLE is ignored. It is not queued.
- Changes to the config inputs after capture have no effect on the running burst.
- Reset, including mid-burst, forces:
  - state IDLE;
  - `busy`=0, `done`=0, `level_out`=0;
  - counters cleared.
- Arithmetic: unsigned. The phase counter loads `max(len,1)-1` and counts down to 0, so there is no wrap-around. The period counter is CNT_W wide, so `n_periods` up to 2^CNT_W-1 is supported.

## Timing
- `start` sampled at edge t: `busy`=1 and `level_out`=LEVEL visible from cycle t+1.
- Burst duration is `n_periods*(H+L)` cycles, where H and L are the effective lengths. The `done` pulse occurs in the cycle immediately after the last LOW cycle.
- With `n_periods`=0: `done` at t+1, `busy` never asserted.
- The earliest next `start` is accepted in the cycle after `done` (IDLE).
- All outputs are registered. There are no combinational input-to-output paths.

## Configuration
- `TOGGLE_SEQ_ABORT_EN` defined:
  - `abort` input exists.
  - `abort`=1 sampled in HIGH or LOW causes the next cycle to be DONE (`level_out`=0, `done`=1). The remaining periods are discarded.
  - `abort` in IDLE or DONE is ignored.
  - `start` and `abort` together in IDLE: `start` wins.
- `TOGGLE_SEQ_ABORT_EN` undefined: no `abort` port, and the burst always runs to completion.

## Structure
- `toggle_seq_pkg` holds:
  - the state enum `toggle_seq_state_t` (IDLE=0, HIGH=1, LOW=2, DONE=3);
  - the `max(len,1)-1` load helper function.
- Sub-module `phase_counter`: CNT_W-bit down-counter with `load`, `load_val` and a `zero` flag. It is instantiated once and reloaded at each phase entry. The period count stays in the top module.

## Test plan
- Reset mid-burst: LEVEL=5, H=3, L=2, N=4, `reset_n` low during the 2nd HIGH → all outputs 0 asynchronously; after release, IDLE with `busy`=0.
- Basic burst: LEVEL=5, H=3, L=2, N=2, `start` at t → `level_out` is 5,5,5,0,0,5,5,5,0,0 over t+1..t+10; `done`=1 at t+11 only; `busy`=1 over t+1..t+10.
- Zero lengths: H=0, L=0, N=3 → `level_out` alternates LEVEL,0 for 6 cycles, then `done`.
- N=0: `start` → `done` at t+1, `busy` stays 0, `level_out` stays 0.
- Start during busy: second `start` with different config mid-burst → ignored; the waveform matches the first config exactly.
- Abort (macro on): H=4, L=4, N=10, `abort` in the 3rd HIGH cycle → `done` next cycle with `level_out`=0, then IDLE. With the macro off, the port is absent and the build still passes.
